btn_debounce: RTL

Input-conditioning stage between the board's raw push-button/switch pins and the SoC. It synchronises and debounces `width` asynchronous inputs, producing stable levels plus one-cycle rise/fall pulses that feed the GPIO input bits. It also generates the SoC synchronous reset `sys_rst` from input 0, stretched after release.

---
 rtl/btn_debounce.sv | 118 +++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Synchronises and debounces raw button/switch inputs, emits rise/fall pulses,
// and derives a stretched SoC reset from channel 0.
module btn_debounce #(
    parameter int unsigned clk_freq    = 50000000,
    parameter int unsigned width       = 4,
    parameter int unsigned debounce_ms = 10,
    parameter int unsigned rst_hold    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [width-1:0] rise,
    output logic [width-1:0] fall,
    output logic             changed,
    output logic             sys_rst
);

    localparam int unsigned DIV = clk_freq / 1000;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = $clog2(debounce_ms + 1);
    localparam int unsigned HW  = $clog2(rst_hold + 1);

    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tick_c;
    logic [width-1:0] s1_q, s1_d;
    logic [width-1:0] s2_q, s2_d;
    logic [width-1:0] dout_q, dout_d;
    logic [width-1:0] rise_q, rise_d;
    logic [width-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CW-1:0]    cnt_q [width];
    logic [CW-1:0]    cnt_d [width];
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             sys_rst_q, sys_rst_d;

    // Free-running prescaler; tick marks the last cycle of each period
    always_comb begin
        tick_c = (pcnt_q == PW'(DIV - 1));
        pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);
    end

    // Per-channel synchroniser, stability counter and commit/pulse generation
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < width; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == dout_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_c) begin
                if (cnt_q[i] == CW'(debounce_ms - 1)) begin
                    cnt_d[i]  = '0;
                    dout_d[i] = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Reset stretcher: hold sys_rst while channel 0 is pressed and rst_hold cycles after
    always_comb begin
        hcnt_d    = hcnt_q;
        sys_rst_d = 1'b0;
        if (dout_q[0]) begin
            hcnt_d    = '0;
            sys_rst_d = 1'b1;
        end else if (hcnt_q != HW'(rst_hold)) begin
            hcnt_d    = hcnt_q + HW'(1);
            sys_rst_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q    <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            dout_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            hcnt_q    <= '0;
            sys_rst_q <= 1'b1;
            for (int unsigned i = 0; i < width; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pcnt_q    <= pcnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            dout_q    <= dout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            hcnt_q    <= hcnt_d;
            sys_rst_q <= sys_rst_d;
            for (int unsigned i = 0; i < width; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;
    assign sys_rst = sys_rst_q;

endmodule
